bram_fifo_ctrl: RTL
===================

// Module: bram_fifo_ctrl
//
// PURPOSE
//  FIFO control stage driving a 1024x8 simple dual-port BRAM (1-cycle registered read, rd_en-gated).
//  - Accepts a valid/ready byte stream and writes it into the BRAM.
//  - Prefetches BRAM reads into a 2-entry output buffer, presenting a first-word-fall-through valid/ready stream.
//  - Sits directly in front of and behind the BRAM: drives its write port, consumes its read data.
//
// PARAMETERS
//  DATA_W  8   stream/BRAM data width
//  ADDR_W  10  BRAM address width; BRAM depth DEPTH = 2**ADDR_W (1024)
//
// PORTS
//  clk          in   1         single clock, all logic on posedge
//  rst_n        in   1         reset, synchronous, active-low
//  s_valid      in   1         input word valid
//  s_ready      out  1         input accept; transfer when s_valid & s_ready at posedge
//  s_data       in   DATA_W    input word
//  m_valid      out  1         output word valid (head of FIFO)
//  m_ready      in   1         downstream accept; pop when m_valid & m_ready
//  m_data       out  DATA_W    output word
//  count        out  ADDR_W+2  total words held (BRAM + in-flight read + output buffer)
//  mem_wr_en    out  1         to BRAM wr_en
//  mem_wr_addr  out  ADDR_W    to BRAM wr_addr
//  mem_wr_data  out  DATA_W    to BRAM wr_data
//  mem_rd_en    out  1         to BRAM rd_en
//  mem_rd_addr  out  ADDR_W    to BRAM rd_addr
//  mem_rd_data  in   DATA_W    from BRAM rd_data, valid the cycle after mem_rd_en sampled
//
// BEHAVIOUR
//  - Reset (rst_n low at posedge): wr_ptr=rd_ptr=0, inflight=0, buffer empty; m_valid=0, count=0.
//    s_ready, mem_wr_en, mem_rd_en forced 0 while rst_n low. m_data don't-care when !m_valid. BRAM contents untouched.
//  - Pointers wr_ptr/rd_ptr are ADDR_W+1 bits (wrap bit); mem_count = wr_ptr - rd_ptr (mod 2**(ADDR_W+1)).
//  - mem_full = (mem_count == DEPTH); s_ready = rst_n & !mem_full (combinational from registers, no m_ready path).
//  - Push: mem_wr_en = s_valid & s_ready; mem_wr_addr = wr_ptr[ADDR_W-1:0]; mem_wr_data = s_data; wr_ptr++ at edge.
//  - Read issue: mem_rd_en = rst_n & (mem_count != 0) & (buf_cnt + inflight - pop < 2), pop = m_valid & m_ready.
//    mem_rd_addr = rd_ptr[ADDR_W-1:0]; rd_ptr++ and inflight<=1 at edge; else inflight<=0.
//  - A word written at edge E is never read in the same cycle (mem_count uses registered wr_ptr) -> no read/write collision.
//  - Return: cycle after issue, mem_rd_data is appended to the output buffer (2 entries, in order).
//  - Output: m_valid = (buf_cnt != 0); m_data = oldest buffer entry. Pop and append in same cycle are legal.
//  - Latency: word accepted at edge E0 -> read issued in cycle after E0 -> captured at E2 -> m_valid high after E2.
//  - Throughput: 1 word/cycle sustained both sides when m_ready held high and FIFO non-empty.
//  - Capacity: DEPTH in BRAM + up to 2 prefetched = DEPTH+2 words. count = mem_count + inflight + buf_cnt.
//  - Full: s_ready low even if m_ready high that cycle (no same-cycle pass-through); frees the cycle after a read issue.
//  - Empty: m_valid low; m_ready ignored; no BRAM read issued.
//  - Wrap: addresses wrap 1023->0; wrap bit distinguishes full from empty.
//  - Reset mid-operation: in-flight BRAM read data on the next cycle is discarded (inflight cleared); no stale word surfaces.
//
// STRUCTURE
//  - Shared package bram_fifo_pkg: default DATA_W/ADDR_W localparams, DEPTH derivation.
//  - One sub-module: bram_fifo_obuf (2-entry in-order output buffer: push/pop/buf_cnt/head), same clk/rst_n.
//  - Top holds pointers, issue logic, count; BRAM instantiated by the parent, not inside this block.
//
// TESTING (bench instantiates this block + the 1024x8 BRAM)
//  - Reset then idle: rst_n low 3 cycles -> m_valid=0, count=0, s_ready=0 during reset, 1 after; no mem_rd_en.
//  - Single word: push 0xA5 at E0, m_ready=1 -> mem_rd_en in next cycle, m_valid=1 & m_data=0xA5 after E2, count 1->0 on pop.
//  - Streaming: push 0..2047 with m_ready=1 every cycle -> output 0..2047 in order, zero bubbles after first word, count<=3.
//  - Fill: m_ready=0, push until s_ready=0 -> exactly 1026 accepted, count=1026, mem_count=1024; one pop -> s_ready=1 next cycle.
//  - Backpressure: random m_ready (50%) and s_valid (70%) over 10k words -> scoreboard exact order, no loss/duplication across wrap.
//  - Reset mid-stream: rst_n low for one cycle right after a mem_rd_en -> m_valid=0, count=0 next cycle; next pushed 0x3C is first out.

Source files
------------

// File: rtl/bram_fifo_pkg.sv
// Shared sizing for the BRAM-backed FIFO controller and its output buffer.
package bram_fifo_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 10;
  localparam int unsigned DEF_DEPTH  = 1 << DEF_ADDR_W;

endpackage

// File: rtl/bram_fifo_ctrl_if.sv
// Valid/ready byte streams into (s_*) and out of (m_*) the BRAM FIFO controller.
interface bram_fifo_ctrl_if
  import bram_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;

  modport master (output s_valid, s_data, m_ready, input s_ready, m_valid, m_data);
  modport slave  (input s_valid, s_data, m_ready, output s_ready, m_valid, m_data);

endinterface

// File: rtl/bram_fifo_obuf.sv
// Two-entry in-order buffer holding BRAM read data prefetched for the output stream.
module bram_fifo_obuf
  import bram_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        buf_cnt,
  output logic [DATA_W-1:0] head
);

  logic [1:0][DATA_W-1:0] ent_q, ent_d;
  logic [1:0]             cnt_q, cnt_d;
  logic                   pop_ok;

  // Entry 0 is always the head; a pop shifts entry 1 down.
  always_comb begin
    ent_d  = ent_q;
    cnt_d  = cnt_q;
    pop_ok = pop & (cnt_q != 2'd0);
    case ({push, pop_ok})
      2'b10: begin
        ent_d[cnt_q[0]] = push_data;
        cnt_d           = cnt_q + 2'd1;
      end
      2'b01: begin
        ent_d[0] = ent_q[1];
        cnt_d    = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          ent_d[0] = push_data;
        end else begin
          ent_d[0] = ent_q[1];
          ent_d[1] = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
    end
    ent_q <= ent_d;
  end

  assign buf_cnt = cnt_q;
  assign head    = ent_q[0];

endmodule

// File: rtl/bram_fifo_ctrl.sv
// FIFO controller in front of a simple dual-port BRAM with FWFT prefetch on the read side.
module bram_fifo_ctrl
  import bram_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  bram_fifo_ctrl_if.slave   bus,
  output logic [ADDR_W+1:0] count,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data
);

  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam int unsigned CNT_W = ADDR_W + 2;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              inflight_q, inflight_d;
  logic [PTR_W-1:0]  mem_count;
  logic              mem_full;
  logic              push, pop;
  logic [2:0]        occ;
  logic [1:0]        buf_cnt;
  logic [DATA_W-1:0] head;

  // Issue a read only when the returning word is guaranteed a buffer slot.
  always_comb begin
    mem_count   = wr_ptr_q - rd_ptr_q;
    mem_full    = (mem_count == PTR_W'(DEPTH));
    bus.s_ready = rst_n & ~mem_full;
    push        = bus.s_valid & rst_n & ~mem_full;
    pop         = (buf_cnt != 2'd0) & bus.m_ready;
    occ         = 3'(buf_cnt) + 3'(inflight_q) - 3'(pop);
    mem_rd_en   = rst_n & (mem_count != '0) & (occ < 3'd2);
    mem_rd_addr = rd_ptr_q[ADDR_W-1:0];
    mem_wr_en   = push;
    mem_wr_addr = wr_ptr_q[ADDR_W-1:0];
    mem_wr_data = bus.s_data;
    wr_ptr_d    = wr_ptr_q + PTR_W'(push);
    rd_ptr_d    = rd_ptr_q + PTR_W'(mem_rd_en);
    inflight_d  = mem_rd_en;
    count       = CNT_W'(mem_count) + CNT_W'(inflight_q) + CNT_W'(buf_cnt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
    end
  end

  bram_fifo_obuf #(.DATA_W(DATA_W)) u_obuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (mem_rd_data),
    .pop       (pop),
    .buf_cnt   (buf_cnt),
    .head      (head)
  );

  assign bus.m_valid = (buf_cnt != 2'd0);
  assign bus.m_data  = head;

endmodule
